lsu_ctrl_mo: RTL and testbench
==============================

// Module: lsu_ctrl_mo
// PURPOSE
//  Multi-outstanding load/store controller between the AGU and the DTCM. It accepts
//   AGU commands and generates the DTCM byte mask and lane-replicated store data.
//  Tracks up to OUTS_DEPTH in-flight accesses in order and aligns and sign/zero-extends
//   load data. Returns one write-back per access, loads and stores, to the long-pipe wbck.
//  Detects misaligned or illegal-size accesses and answers them with an in-order error
//   write-back, without issuing them to the DTCM.
// PARAMETERS
//  XLEN        32  data width; must be 32
//  AW          16  DTCM byte-address width
//  ITAG_W      1   instruction tag width
//  OUTS_DEPTH  2   max outstanding accesses, >=1; tracking FIFO depth
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       synchronous, active-high reset
//  agu_cmd_valid    in   1       AGU command valid
//  agu_cmd_ready    out  1       LSU accepts command
//  agu_cmd_read     in   1       1=load, 0=store
//  agu_cmd_addr     in   AW      byte address
//  agu_cmd_wdata    in   XLEN    store data, LSB-justified
//  agu_cmd_size     in   2       00=byte 01=half 10=word 11=illegal
//  agu_cmd_usign    in   1       load zero-extend
//  agu_cmd_itag     in   ITAG_W  instruction tag
//  dtcm_cmd_valid   out  1       DTCM request
//  dtcm_cmd_ready   in   1       DTCM accepts request
//  dtcm_cmd_read    out  1       DTCM read
//  dtcm_cmd_addr    out  AW      word-aligned address {addr[AW-1:2],2'b00}
//  dtcm_cmd_wdata   out  XLEN    replicated store data
//  dtcm_cmd_wmask   out  XLEN/8  byte enables (all 0 on read)
//  dtcm_rsp_valid   in   1       DTCM response, in request order
//  dtcm_rsp_ready   out  1       LSU accepts response
//  dtcm_rsp_rdata   in   XLEN    read data (don't-care for stores)
//  dtcm_rsp_err     in   1       DTCM bus error
//  lsu_o_valid      out  1       write-back valid
//  lsu_o_ready      in   1       write-back accepted
//  lsu_o_wbck_data  out  XLEN    load result; 0 for stores and errors
//  lsu_o_wbck_itag  out  ITAG_W  tag of retiring access
//  lsu_o_wbck_err   out  1       misalign/illegal/bus error
//  lsu_o_wbck_read  out  1       1 = retiring access was a load
// BEHAVIOUR
//  - Reset: FIFO empty, count=0. Outputs during and after reset: agu_cmd_ready=1,
//    dtcm_cmd_valid=0, dtcm_rsp_ready=0, lsu_o_valid=0, all data/tag/err outputs 0.
//  - mis = size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
//  - full = (count==OUTS_DEPTH). agu_cmd_ready = !full & (mis | dtcm_cmd_ready).
//  - dtcm_cmd_valid = agu_cmd_valid & !full & !mis. No bypass: a push into a full FIFO
//    is refused even when a pop occurs in the same cycle.
//  - Mask by size: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
//  - Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
//  - Push on AGU handshake. Entry = {itag, read, usign, size, addr[1:0], mis}.
//  - Head entry with mis=1: lsu_o_valid=1, err=1, data=0, and dtcm_rsp_ready=0.
//    Its earliest write-back is the cycle after acceptance.
//  - Head entry with mis=0: lsu_o_valid = dtcm_rsp_valid; dtcm_rsp_ready = lsu_o_ready.
//    DTCM backpressure is passed through combinationally. err = dtcm_rsp_err.
//  - Pop on lsu_o_valid & lsu_o_ready. Simultaneous push and pop leaves count unchanged.
//  - Load data: r = rdata >> {addr[1:0],3'b0}. Extend by size/usign: lb, lbu, lh, lhu, lw.
//    Data is 0 when err=1 or read=0.
//  - A DTCM response while the FIFO is empty or the head is mis is a protocol violation.
//    dtcm_rsp_ready=0 in that case, and the bench flags it with an assertion.
//  - Reset asserted mid-operation flushes all entries. In-flight DTCM responses after
//    reset are the DTCM's responsibility and are covered by the same assertion.
//  - Latency: DTCM response to write-back is combinational, 0 cycles. Min load-use = 1.
//  - Throughput: 1 access/cycle when OUTS_DEPTH >= DTCM latency + 1.
// STRUCTURE
//  - lsu_pkg: size encodings (LSU_SZ_B/H/W), lsu_ent_t entry struct, and mask/replicate
//    functions shared with the AGU.
//  - Sub-module gnrl_sync_fifo #(DW,DP): synchronous, active-high reset, with full, empty
//    and count. Pointers use $clog2(DP) bits; count uses $clog2(DP)+1 bits.
//    DP=1 must be supported.
//  - Everything else is combinational in lsu_ctrl_mo.
// TESTING
//  1. lw addr=0x10 -> dtcm rdata=0x8765_4321 -> wbck_data=0x8765_4321, err=0, read=1.
//  2. lb addr=0x13, rdata=0x80xx_xxxx -> 0xFFFF_FF80; lbu -> 0x0000_0080;
//     lhu addr=0x12 -> 0x0000_80xx.
//  3. sh addr=0x6, wdata=0xABCD -> wmask=4'b1100, wdata=0xABCD_ABCD, addr=0x4;
//     rsp -> wbck read=0, data=0.
//  4. lw addr=0x2 between two legal loads -> no DTCM request issued; three write-backs
//     in order, the middle one with err=1.
//  5. OUTS_DEPTH=2, dtcm_cmd_ready=1, rsp delayed 3 cycles -> agu_cmd_ready=0 after 2
//     pushes, reasserts the cycle after the first pop.
//  6. lsu_o_ready=0 for 4 cycles with rsp_valid=1 -> rsp held, dtcm_rsp_ready=0;
//     reset mid-stream -> count=0, lsu_o_valid=0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, the tracking-entry
// layout and the byte-mask / store-data replication helpers also used by the AGU.
package lsu_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  // The instruction tag is carried beside this struct so its width stays a top parameter
  typedef struct packed {
    logic       read;
    logic       usign;
    logic [1:0] size;
    logic [1:0] addr_lo;
    logic       mis;
  } lsu_ent_t;

  function automatic logic lsu_misalign(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    case (size)
      LSU_SZ_B: m = 1'b0;
      LSU_SZ_H: m = addr_lo[0];
      LSU_SZ_W: m = (addr_lo != 2'b00);
      default:  m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lsu_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      LSU_SZ_B: m = 4'b0001 << addr_lo;
      LSU_SZ_H: m = 4'b0011 << addr_lo;
      default:  m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lsu_repl(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      LSU_SZ_B: d = {4{wdata[7:0]}};
      LSU_SZ_H: d = {2{wdata[15:0]}};
      default:  d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_ctrl_mo_fifo.sv
// Small synchronous FIFO with full/empty/count; head is readable in the same cycle
// it becomes valid so the write-back path can stay combinational.
module gnrl_sync_fifo #(
  parameter int DW = 8,
  parameter int DP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  output logic              full,
  output logic              empty,
  output logic [$clog2(DP):0] count
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP) + 1;

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DP));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/lsu_ctrl_mo.sv
// Multi-outstanding LSU between AGU and DTCM: issues requests, tracks them in order,
// and retires one write-back per access (misaligned ones retire as errors, never issued).
module lsu_ctrl_mo
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 16,
  parameter int ITAG_W     = 1,
  parameter int OUTS_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agu_cmd_valid,
  output logic              agu_cmd_ready,
  input  logic              agu_cmd_read,
  input  logic [AW-1:0]     agu_cmd_addr,
  input  logic [XLEN-1:0]   agu_cmd_wdata,
  input  logic [1:0]        agu_cmd_size,
  input  logic              agu_cmd_usign,
  input  logic [ITAG_W-1:0] agu_cmd_itag,
  output logic              dtcm_cmd_valid,
  input  logic              dtcm_cmd_ready,
  output logic              dtcm_cmd_read,
  output logic [AW-1:0]     dtcm_cmd_addr,
  output logic [XLEN-1:0]   dtcm_cmd_wdata,
  output logic [XLEN/8-1:0] dtcm_cmd_wmask,
  input  logic              dtcm_rsp_valid,
  output logic              dtcm_rsp_ready,
  input  logic [XLEN-1:0]   dtcm_rsp_rdata,
  input  logic              dtcm_rsp_err,
  output logic              lsu_o_valid,
  input  logic              lsu_o_ready,
  output logic [XLEN-1:0]   lsu_o_wbck_data,
  output logic [ITAG_W-1:0] lsu_o_wbck_itag,
  output logic              lsu_o_wbck_err,
  output logic              lsu_o_wbck_read
);

  localparam int EW = ITAG_W + $bits(lsu_ent_t);
  localparam int CW = $clog2(OUTS_DEPTH) + 1;

  logic              cmd_mis, full, push, pop, head_err;
  logic              fifo_empty, fifo_full_unused;
  logic [CW-1:0]     fifo_count;
  lsu_ent_t          push_ent, head_ent;
  logic [ITAG_W-1:0] head_itag;
  logic [EW-1:0]     fifo_dout;
  logic [XLEN-1:0]   rshift, ld_data;

  assign cmd_mis = lsu_misalign(agu_cmd_size, agu_cmd_addr[1:0]);
  assign full    = (fifo_count == CW'(OUTS_DEPTH));

  // Request side; full is taken from the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    agu_cmd_ready  = ~full & (cmd_mis | dtcm_cmd_ready);
    dtcm_cmd_valid = agu_cmd_valid & ~full & ~cmd_mis;
    if (rst) begin
      agu_cmd_ready  = 1'b1;
      dtcm_cmd_valid = 1'b0;
    end
    dtcm_cmd_read  = dtcm_cmd_valid & agu_cmd_read;
    dtcm_cmd_addr  = dtcm_cmd_valid ? {agu_cmd_addr[AW-1:2], 2'b00} : '0;
    dtcm_cmd_wdata = dtcm_cmd_valid ? lsu_repl(agu_cmd_size, agu_cmd_wdata) : '0;
    dtcm_cmd_wmask = (dtcm_cmd_valid & ~agu_cmd_read) ?
                     lsu_mask(agu_cmd_size, agu_cmd_addr[1:0]) : '0;
  end

  assign push = agu_cmd_valid & agu_cmd_ready & ~rst;

  always_comb begin
    push_ent         = '0;
    push_ent.read    = agu_cmd_read;
    push_ent.usign   = agu_cmd_usign;
    push_ent.size    = agu_cmd_size;
    push_ent.addr_lo = agu_cmd_addr[1:0];
    push_ent.mis     = cmd_mis;
  end

  gnrl_sync_fifo #(
    .DW(EW),
    .DP(OUTS_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({agu_cmd_itag, push_ent}),
    .dout  (fifo_dout),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_itag, head_ent} = fifo_dout;

  // Retire side: a misaligned head answers on its own, otherwise it waits for the DTCM
  assign lsu_o_valid    = ~rst & ~fifo_empty & (head_ent.mis | dtcm_rsp_valid);
  assign dtcm_rsp_ready = ~rst & ~fifo_empty & ~head_ent.mis & lsu_o_ready;
  assign pop            = lsu_o_valid & lsu_o_ready;
  assign head_err       = head_ent.mis | dtcm_rsp_err;
  assign rshift         = dtcm_rsp_rdata >> {head_ent.addr_lo, 3'b000};

  always_comb begin
    case (head_ent.size)
      LSU_SZ_B: ld_data = head_ent.usign ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                         : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      LSU_SZ_H: ld_data = head_ent.usign ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                         : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      default:  ld_data = rshift;
    endcase
  end

  assign lsu_o_wbck_data = (lsu_o_valid & ~head_err & head_ent.read) ? ld_data : '0;
  assign lsu_o_wbck_itag = lsu_o_valid ? head_itag : '0;
  assign lsu_o_wbck_err  = lsu_o_valid & head_err;
  assign lsu_o_wbck_read = lsu_o_valid & head_ent.read;

endmodule

// File: tb/tb_lsu_ctrl_mo.sv
// Self-checking bench for lsu_ctrl_mo: directed scenarios plus randomized traffic,
// compared against an in-order queue model and a latency-driven DTCM model.
module tb_lsu_ctrl_mo;

  localparam int XLEN  = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            agu_cmd_valid = 0, agu_cmd_ready, agu_cmd_read = 0;
  logic [AW-1:0]   agu_cmd_addr = '0;
  logic [XLEN-1:0] agu_cmd_wdata = '0;
  logic [1:0]      agu_cmd_size = '0;
  logic            agu_cmd_usign = 0;
  logic [0:0]      agu_cmd_itag = '0;
  logic            dtcm_cmd_valid, dtcm_cmd_ready = 0, dtcm_cmd_read;
  logic [AW-1:0]   dtcm_cmd_addr;
  logic [XLEN-1:0] dtcm_cmd_wdata;
  logic [3:0]      dtcm_cmd_wmask;
  logic            dtcm_rsp_valid = 0, dtcm_rsp_ready, dtcm_rsp_err = 0;
  logic [XLEN-1:0] dtcm_rsp_rdata = '0;
  logic            lsu_o_valid, lsu_o_ready = 0;
  logic [XLEN-1:0] lsu_o_wbck_data;
  logic [0:0]      lsu_o_wbck_itag;
  logic            lsu_o_wbck_err, lsu_o_wbck_read;

  always #5 clk = ~clk;

  lsu_ctrl_mo #(.XLEN(XLEN), .AW(AW), .ITAG_W(1), .OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_usign(agu_cmd_usign), .agu_cmd_itag(agu_cmd_itag),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata), .dtcm_rsp_err(dtcm_rsp_err),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_data(lsu_o_wbck_data),
    .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_wbck_err(lsu_o_wbck_err),
    .lsu_o_wbck_read(lsu_o_wbck_read)
  );

  typedef struct {
    bit       rd;
    bit       us;
    bit       mis;
    bit [1:0] sz;
    bit [1:0] lo;
    bit       tg;
  } ment_t;

  ment_t     mq[$];       // accepted accesses not yet written back, in order
  int        dq[$];       // earliest response cycle of each issued DTCM request
  bit [31:0] rd_q[$];     // preset read data for directed responses
  bit        wb_err_log[$];
  int        n_cmp = 0, n_bad = 0, cyc = 0, lat_fix = 0, n_issue = 0;
  bit        rsp_on = 0, verbose = 1;
  bit [31:0] last_wb_data, last_dwdata;
  bit        last_wb_err, last_wb_read, last_agu_rdy;
  bit [3:0]  last_wmask;
  bit [15:0] last_daddr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_mis(input bit [1:0] sz, input bit [15:0] a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic bit [31:0] load_val(input ment_t e, input bit [31:0] rdata);
    bit [31:0] v;
    v = rdata >> (8 * e.lo);
    if (e.sz == 0) begin
      v = v & 32'hFF;
      if (!e.us && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (e.sz == 1) begin
      v = v & 32'hFFFF;
      if (!e.us && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One clock cycle: drive inputs, compare every output against the model, update the model
  task automatic step(input bit v, input bit rd, input bit [15:0] a, input bit [31:0] wd,
                      input bit [1:0] sz, input bit us, input bit tg,
                      input bit cr, input bit orr, output bit acc);
    bit        mis, exp_rdy, exp_dv, exp_ov, exp_rr, err;
    bit [1:0]  lo;
    int        mi;
    bit [31:0] w, d;
    ment_t     e, ne;
    @(negedge clk);
    agu_cmd_valid = v;  agu_cmd_read = rd;  agu_cmd_addr = a;  agu_cmd_wdata = wd;
    agu_cmd_size = sz;  agu_cmd_usign = us; agu_cmd_itag = tg;
    dtcm_cmd_ready = cr; lsu_o_ready = orr;
    if (!rsp_on && mq.size() > 0 && !mq[0].mis && dq.size() > 0 && cyc >= dq[0]) begin
      rsp_on = 1;
      if (rd_q.size() > 0) begin
        dtcm_rsp_rdata = rd_q.pop_front();
        dtcm_rsp_err   = 0;
      end else begin
        dtcm_rsp_rdata = $urandom;
        dtcm_rsp_err   = ($urandom_range(0, 15) == 0);
      end
    end
    if (!rsp_on) dtcm_rsp_err = 0;
    dtcm_rsp_valid = rsp_on;
    #1;
    assert (!(dtcm_rsp_valid && (mq.size() == 0 || mq[0].mis)))
      else $error("protocol violation: DTCM response with no pending DTCM access at head");

    mis     = is_mis(sz, a);
    lo      = 2'(a % 4);
    exp_rdy = (mq.size() < DEPTH) && (mis || cr);
    exp_dv  = v && (mq.size() < DEPTH) && !mis;
    check_eq("agu_cmd_ready", agu_cmd_ready, exp_rdy);
    check_eq("dtcm_cmd_valid", dtcm_cmd_valid, exp_dv);
    last_agu_rdy = agu_cmd_ready;
    if (exp_dv) begin
      mi = rd ? 0 : (sz == 0) ? (1 << lo) : (sz == 1) ? (3 << lo) : 15;
      w  = (sz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
           (sz == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      check_eq("dtcm_cmd_read", dtcm_cmd_read, rd);
      check_eq("dtcm_cmd_addr", dtcm_cmd_addr, a - (a % 4));
      check_eq("dtcm_cmd_wmask", dtcm_cmd_wmask, mi);
      check_eq("dtcm_cmd_wdata", dtcm_cmd_wdata, w);
      last_wmask = dtcm_cmd_wmask; last_dwdata = dtcm_cmd_wdata; last_daddr = dtcm_cmd_addr;
    end

    exp_ov = (mq.size() > 0) && (mq[0].mis || rsp_on);
    exp_rr = (mq.size() > 0) && !mq[0].mis && orr;
    check_eq("lsu_o_valid", lsu_o_valid, exp_ov);
    check_eq("dtcm_rsp_ready", dtcm_rsp_ready, exp_rr);
    if (exp_ov && orr) begin
      e   = mq.pop_front();
      err = e.mis || dtcm_rsp_err;
      d   = (err || !e.rd) ? 32'h0 : load_val(e, dtcm_rsp_rdata);
      check_eq("wbck_data", lsu_o_wbck_data, d);
      check_eq("wbck_itag", lsu_o_wbck_itag, e.tg);
      check_eq("wbck_err", lsu_o_wbck_err, err);
      check_eq("wbck_read", lsu_o_wbck_read, e.rd);
      last_wb_data = lsu_o_wbck_data; last_wb_err = lsu_o_wbck_err; last_wb_read = lsu_o_wbck_read;
      wb_err_log.push_back(err);
      if (verbose)
        $display("wb cyc=%0d itag=%0d read=%0d err=%0d data=%h",
                 cyc, lsu_o_wbck_itag, lsu_o_wbck_read, lsu_o_wbck_err, lsu_o_wbck_data);
      if (!e.mis) begin
        void'(dq.pop_front());
        rsp_on = 0;
      end
    end

    acc = v && exp_rdy;
    if (acc) begin
      ne.rd = rd; ne.us = us; ne.mis = mis; ne.sz = sz; ne.lo = lo; ne.tg = tg;
      mq.push_back(ne);
    end
    if (exp_dv && cr) begin
      dq.push_back(cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3))));
      n_issue++;
    end
    cyc++;
  endtask

  task automatic issue(input bit rd, input bit [15:0] a, input bit [31:0] wd, input bit [1:0] sz,
                       input bit us, input bit tg, output int tries);
    bit acc;
    acc = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1, rd, a, wd, sz, us, tg, 1, 1, acc);
      tries++;
    end
    if (!acc) check_eq("issue_timeout", acc, 1);
  endtask

  task automatic idle(input bit orr);
    bit acc;
    step(0, 0, 16'h0, 32'h0, 2'b00, 0, 0, 1, orr, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    check_eq("drain_empty", mq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    agu_cmd_valid = 1; agu_cmd_read = 0; agu_cmd_addr = 16'h1235; agu_cmd_wdata = 32'hDEAD_BEEF;
    agu_cmd_size = 2'b00; dtcm_cmd_ready = 0; lsu_o_ready = 1;
    dtcm_rsp_valid = 0; dtcm_rsp_err = 0;
    #1;
    check_eq("rst_agu_ready", agu_cmd_ready, 1);
    check_eq("rst_dtcm_valid", dtcm_cmd_valid, 0);
    check_eq("rst_dtcm_addr", dtcm_cmd_addr, 0);
    check_eq("rst_dtcm_wdata", dtcm_cmd_wdata, 0);
    check_eq("rst_dtcm_wmask", dtcm_cmd_wmask, 0);
    check_eq("rst_rsp_ready", dtcm_rsp_ready, 0);
    check_eq("rst_lsu_valid", lsu_o_valid, 0);
    check_eq("rst_wbck_data", lsu_o_wbck_data, 0);
    check_eq("rst_wbck_itag", lsu_o_wbck_itag, 0);
    check_eq("rst_wbck_err", lsu_o_wbck_err, 0);
    check_eq("rst_wbck_read", lsu_o_wbck_read, 0);
    mq.delete(); dq.delete(); rd_q.delete();
    rsp_on = 0;
    @(negedge clk);
    rst = 0;
    agu_cmd_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int tries, base;
    bit acc;
    do_reset();
    lat_fix = 1;

    // lw from 0x10
    rd_q.push_back(32'h8765_4321);
    issue(1, 16'h0010, 32'h0, 2'b10, 0, 1, tries);
    drain();
    check_eq("t1_lw_data", last_wb_data, 32'h8765_4321);
    check_eq("t1_lw_err", last_wb_err, 0);
    check_eq("t1_lw_read", last_wb_read, 1);

    // lb / lbu at byte 3, lhu at the upper half
    rd_q.push_back(32'h8012_3456);
    issue(1, 16'h0013, 32'h0, 2'b00, 0, 0, tries);
    drain();
    check_eq("t2_lb", last_wb_data, 32'hFFFF_FF80);
    rd_q.push_back(32'h8012_3456);
    issue(1, 16'h0013, 32'h0, 2'b00, 1, 0, tries);
    drain();
    check_eq("t2_lbu", last_wb_data, 32'h0000_0080);
    rd_q.push_back(32'h8012_3456);
    issue(1, 16'h0012, 32'h0, 2'b01, 1, 0, tries);
    drain();
    check_eq("t2_lhu", last_wb_data, 32'h0000_8012);

    // sh to 0x6
    issue(0, 16'h0006, 32'h0000_ABCD, 2'b01, 0, 1, tries);
    check_eq("t3_wmask", last_wmask, 4'b1100);
    check_eq("t3_wdata", last_dwdata, 32'hABCD_ABCD);
    check_eq("t3_addr", last_daddr, 16'h0004);
    drain();
    check_eq("t3_wb_read", last_wb_read, 0);
    check_eq("t3_wb_data", last_wb_data, 0);

    // misaligned lw sandwiched between two legal loads
    wb_err_log.delete();
    base = n_issue;
    rd_q.push_back(32'h1111_1111);
    rd_q.push_back(32'h2222_2222);
    issue(1, 16'h0010, 32'h0, 2'b10, 0, 0, tries);
    issue(1, 16'h0002, 32'h0, 2'b10, 0, 1, tries);
    issue(1, 16'h0014, 32'h0, 2'b10, 0, 0, tries);
    drain();
    check_eq("t4_issued", n_issue - base, 2);
    check_eq("t4_wb_count", wb_err_log.size(), 3);
    if (wb_err_log.size() == 3) begin
      check_eq("t4_err0", wb_err_log[0], 0);
      check_eq("t4_err1", wb_err_log[1], 1);
      check_eq("t4_err2", wb_err_log[2], 0);
    end

    // response latency 3 fills the tracker; ready returns the cycle after the first pop
    lat_fix = 3;
    issue(1, 16'h0020, 32'h0, 2'b10, 0, 0, tries);
    issue(1, 16'h0024, 32'h0, 2'b10, 0, 1, tries);
    issue(1, 16'h0028, 32'h0, 2'b10, 0, 0, tries);
    check_eq("t5_third_tries", tries, 3);
    drain();

    // write-back stalled with a response pending, then reset mid-stream
    lat_fix = 1;
    issue(1, 16'h0030, 32'h0, 2'b10, 0, 1, tries);
    issue(1, 16'h0034, 32'h0, 2'b10, 0, 0, tries);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      check_eq("t6_rsp_held", dtcm_rsp_valid, 1);
    end
    do_reset();
    idle(1);
    check_eq("t6_post_rst_valid", lsu_o_valid, 0);
    check_eq("t6_post_rst_ready", last_agu_rdy, 1);

    // randomized traffic with one reset in the middle
    verbose = 0;
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
           $urandom, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), acc);
      if (i == 1500) do_reset();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
